// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// Shared definitions for the Simulink-to-PPC snapshot register and its OPB ack sequencer.
package opb_register_simulink2ppc_snap_pkg;

    // Word indices inside the 4-word register window
    localparam logic [1:0] IDX_DATA    = 2'd0;
    localparam logic [1:0] IDX_STATUS  = 2'd1;
    localparam logic [1:0] IDX_CONTROL = 2'd2;

    // OPB slave handshake states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        HOLD = 2'd2
    } ack_state_e;

    // STATUS word layout
    localparam int unsigned STATUS_FRESH_BIT = 31;
    localparam int unsigned STATUS_OVR_LSB   = 0;
    localparam int unsigned OVR_WIDTH        = 16;

    localparam logic [OVR_WIDTH-1:0] OVR_MAX = 16'hFFFF;

    // Pack the fresh flag and overrun count into the STATUS read word
    function automatic logic [31:0] status_word(input logic                 fresh,
                                                input logic [OVR_WIDTH-1:0] ovr);
        logic [31:0] w;
        w = '0;
        w[STATUS_FRESH_BIT] = fresh;
        w[STATUS_OVR_LSB +: OVR_WIDTH] = ovr;
        return w;
    endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_snap_ack_fsm.sv
// OPB slave address decode and single-cycle acknowledge sequencer, reusable by OPB registers.
module opb_slave_ack_fsm
    import opb_register_simulink2ppc_snap_pkg::*;
#(
    parameter int unsigned       AWIDTH   = 32,
    parameter logic [AWIDTH-1:0] BASEADDR = '0,
    parameter logic [AWIDTH-1:0] HIGHADDR = '1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [0:AWIDTH-1] i_abus,
    input  logic              i_rnw,
    input  logic              i_select,
    output logic              o_rd_hit,   // read hit at this edge; source regs are sampled now
    output logic [1:0]        o_idx,      // word index of the current address
    output logic              o_wr_en,    // write commits at the edge ending the ack cycle
    output logic [1:0]        o_wr_idx,   // word index latched for the pending write
    output logic              o_ack
);

    logic [AWIDTH-1:0] w_addr;
    logic [AWIDTH:0]   w_lo_diff;
    logic [AWIDTH:0]   w_hi_diff;
    logic              w_hit;
    logic              w_unused;

    ack_state_e        r_state;
    logic              r_ack;
    logic              r_wr;
    logic [1:0]        r_idx;

    // OPB bit 0 is the MSB, so a plain assignment gives the numeric address
    assign w_addr = i_abus;

    // Window check via borrow bits so it stays meaningful for any base/high pair
    assign w_lo_diff = {1'b0, w_addr} - {1'b0, BASEADDR};
    assign w_hi_diff = {1'b0, HIGHADDR} - {1'b0, w_addr};
    assign w_hit     = i_select & ~w_lo_diff[AWIDTH] & ~w_hi_diff[AWIDTH];

    assign o_idx    = i_abus[AWIDTH-4:AWIDTH-3];
    assign o_rd_hit = (r_state == IDLE) & w_hit & i_rnw;
    assign o_wr_en  = r_wr;
    assign o_wr_idx = r_idx;
    assign o_ack    = r_ack;

    assign w_unused = ^{w_lo_diff[AWIDTH-1:0], w_hi_diff[AWIDTH-1:0], i_abus[AWIDTH-2:AWIDTH-1]};

    // One ack per select assertion; a new transfer needs select to drop first
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_wr    <= 1'b0;
            r_idx   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_wr    <= ~i_rnw;
                        r_idx   <= o_idx;
                    end
                end
                ACK: begin
                    r_state <= HOLD;
                    r_ack   <= 1'b0;
                    r_wr    <= 1'b0;
                end
                HOLD: begin
                    if (!i_select) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ack   <= 1'b0;
                    r_wr    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Captures a user word on a valid strobe and exposes it, a fresh flag, an overrun count and a
// freeze control to the PowerPC over OPB.
module opb_register_simulink2ppc_snap
    import opb_register_simulink2ppc_snap_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h0000_000F,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex6"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_xferAck,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    input  logic [31:0]             user_data_in,
    input  logic                    user_valid,
    output logic                    user_freeze
);

    logic                 w_rd_hit;
    logic [1:0]           w_idx;
    logic                 w_wr_en;
    logic [1:0]           w_wr_idx;
    logic                 w_ack;
    logic                 w_capture;
    logic                 w_data_read;
    logic                 w_status_wr;
    logic                 w_ctrl_wr;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    logic [31:0]          r_data;
    logic                 r_fresh;
    logic [OVR_WIDTH-1:0] r_ovr;
    logic                 r_freeze;
    logic [31:0]          r_dbus;

    opb_slave_ack_fsm #(
        .AWIDTH   (C_OPB_AWIDTH),
        .BASEADDR (C_BASEADDR[C_OPB_AWIDTH-1:0]),
        .HIGHADDR (C_HIGHADDR[C_OPB_AWIDTH-1:0])
    ) u_ack_fsm (
        .i_clk    (OPB_Clk),
        .i_rst    (OPB_Rst),
        .i_abus   (OPB_ABus),
        .i_rnw    (OPB_RNW),
        .i_select (OPB_select),
        .o_rd_hit (w_rd_hit),
        .o_idx    (w_idx),
        .o_wr_en  (w_wr_en),
        .o_wr_idx (w_wr_idx),
        .o_ack    (w_ack)
    );

    assign w_capture   = user_valid & ~r_freeze;
    assign w_data_read = w_rd_hit & (w_idx == IDX_DATA);
    assign w_status_wr = w_wr_en & (w_wr_idx == IDX_STATUS);
    assign w_ctrl_wr   = w_wr_en & (w_wr_idx == IDX_CONTROL);

    // Register file read mux, sampled before any same-edge update
    always_comb begin
        w_rdata = '0;
        unique case (w_idx)
            IDX_DATA:    w_rdata = r_data;
            IDX_STATUS:  w_rdata = status_word(r_fresh, r_ovr);
            IDX_CONTROL: w_rdata = {31'b0, r_freeze};
            default:     w_rdata = '0;
        endcase
    end

    // Capture path: a capture beats the read-clear of fresh; a STATUS write beats the count
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_data  <= '0;
            r_fresh <= 1'b0;
            r_ovr   <= '0;
        end else begin
            if (w_capture) begin
                r_data <= user_data_in;
            end

            if (w_capture) begin
                r_fresh <= 1'b1;
            end else if (w_data_read) begin
                r_fresh <= 1'b0;
            end

            // The old word is consumed by a same-edge DATA read, so that capture is no overrun
            if (w_status_wr) begin
                r_ovr <= '0;
            end else if (w_capture && r_fresh && !w_data_read && (r_ovr != OVR_MAX)) begin
                r_ovr <= r_ovr + 1'b1;
            end
        end
    end

    // Freeze control, written from the LSB of the OPB data word
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_freeze <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_freeze <= OPB_DBus[C_OPB_DWIDTH-1];
        end
    end

    // Read data is only non-zero during the ack cycle because the bus is OR-combined
    always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
        if (OPB_Rst) begin
            r_dbus <= '0;
        end else if (w_rd_hit) begin
            r_dbus <= w_rdata;
        end else begin
            r_dbus <= '0;
        end
    end

    assign Sl_DBus     = r_dbus;
    assign Sl_xferAck  = w_ack;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_freeze = r_freeze;

    assign w_unused = ^{OPB_BE, OPB_seqAddr, OPB_DBus[0:C_OPB_DWIDTH-2], (C_FAMILY == "")};

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Scoreboard bench: transfers push expected acks, a negedge monitor pops and compares them.
module tb_opb_register_simulink2ppc_snap;

    localparam logic [31:0] BASE     = 32'h4000_0000;
    localparam logic [31:0] A_DATA   = BASE;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_CTRL   = BASE + 32'h8;
    localparam logic [31:0] A_RSV    = BASE + 32'hF;

    typedef struct {
        logic [31:0] data;
        int unsigned cyc;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [0:31] abus;
    logic [0:3]  be;
    logic [0:31] dbus_in;
    logic        rnw;
    logic        select;
    logic        seqaddr;
    logic [0:31] sl_dbus;
    logic        xferack;
    logic        erra;
    logic        retry;
    logic        tout;
    logic [31:0] udata;
    logic        uvalid;
    logic        ufreeze;

    exp_t        exp_q[$];
    int unsigned cyc;
    int          n_checks;
    int          n_pass;
    int          unexpected;
    int          viol;

    opb_register_simulink2ppc_snap #(
        .C_BASEADDR   (32'h4000_0000),
        .C_HIGHADDR   (32'h4000_000F),
        .C_OPB_AWIDTH (32),
        .C_OPB_DWIDTH (32),
        .C_FAMILY     ("virtex6")
    ) dut (
        .OPB_Clk      (clk),
        .OPB_Rst      (rst),
        .OPB_ABus     (abus),
        .OPB_BE       (be),
        .OPB_DBus     (dbus_in),
        .OPB_RNW      (rnw),
        .OPB_select   (select),
        .OPB_seqAddr  (seqaddr),
        .Sl_DBus      (sl_dbus),
        .Sl_xferAck   (xferack),
        .Sl_errAck    (erra),
        .Sl_retry     (retry),
        .Sl_toutSup   (tout),
        .user_data_in (udata),
        .user_valid   (uvalid),
        .user_freeze  (ufreeze)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One OPB transfer; select held for `hold` edges
    task automatic xfer(input logic [31:0] a, input logic r, input logic [31:0] wd,
                        input logic [31:0] exp, input bit expect_ack, input string nm,
                        input int hold);
        @(posedge clk);
        #1;
        abus    = a;
        rnw     = r;
        dbus_in = wd;
        select  = 1'b1;
        if (expect_ack) exp_q.push_back('{data: exp, cyc: cyc + 1, name: nm});
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            if (k == 0 && !expect_ack) begin
                @(negedge clk);
                check({nm, "_noack"}, {31'b0, xferack}, 32'h0);
                check({nm, "_dbus"}, sl_dbus, 32'h0);
            end
        end
        #1;
        select  = 1'b0;
        rnw     = 1'b0;
        dbus_in = '0;
        repeat (2) @(posedge clk);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        xfer(a, 1'b1, 32'h0, exp, 1'b1, nm, 2);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input string nm);
        xfer(a, 1'b0, d, 32'h0, 1'b1, nm, 2);
    endtask

    // n back-to-back captures of base, base+1, ...
    task automatic capture_seq(input logic [31:0] base, input int n);
        @(posedge clk);
        #1;
        uvalid = 1'b1;
        for (int i = 0; i < n; i++) begin
            udata = base + i;
            @(posedge clk);
            #1;
        end
        uvalid = 1'b0;
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, "_ack"}, {31'b0, xferack}, 32'h0);
        check({nm, "_dbus"}, sl_dbus, 32'h0);
        check({nm, "_freeze"}, {31'b0, ufreeze}, 32'h0);
        check({nm, "_err_retry_tout"}, {29'b0, erra, retry, tout}, 32'h0);
    endtask

    // Monitor: pops one expectation per ack, flags stray acks and a non-idle bus
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (xferack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    unexpected++;
                    $display("FAIL unexpected_ack: ack at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check({e.name, "_data"}, sl_dbus, e.data);
                    check({e.name, "_latency"}, cyc, e.cyc);
                end
            end else if (sl_dbus !== '0) begin
                viol++;
                $display("FAIL idle_dbus: got %h at cycle %0d, expected 0", sl_dbus, cyc);
            end
            if ((erra | retry | tout) !== 1'b0) begin
                viol++;
                $display("FAIL tied_outputs: got %b%b%b, expected 000", erra, retry, tout);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        abus    = '0;
        be      = 4'hF;
        dbus_in = '0;
        rnw     = 1'b0;
        select  = 1'b0;
        seqaddr = 1'b0;
        udata   = '0;
        uvalid  = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset contents of all four words, including the top byte of the window
        rd(A_DATA,   32'h0, "rst_data");
        rd(A_STATUS, 32'h0, "rst_status");
        rd(A_CTRL,   32'h0, "rst_ctrl");
        rd(A_RSV,    32'h0, "rst_rsv");

        // Single capture, fresh cleared by the DATA read
        capture_seq(32'hDEAD_BEEF, 1);
        rd(A_STATUS, 32'h8000_0000, "cap1_status");
        rd(A_DATA,   32'hDEAD_BEEF, "cap1_data");
        rd(A_STATUS, 32'h0000_0000, "cap1_status_after");

        // Back-to-back captures and overrun counting
        capture_seq(32'h1, 3);
        rd(A_STATUS, 32'h8000_0002, "ovr2_status");
        wr(A_STATUS, 32'hFFFF_FFFF, "ovr_clear_wr");
        rd(A_STATUS, 32'h8000_0000, "ovr_cleared");
        rd(A_DATA,   32'h0000_0003, "ovr_data");

        // Saturation: 69999 overruns clamp at 16'hFFFF
        capture_seq(32'h0, 70000);
        rd(A_STATUS, 32'h8000_FFFF, "sat_status");
        wr(A_STATUS, 32'h0, "sat_clear_wr");
        rd(A_STATUS, 32'h8000_0000, "sat_cleared");
        rd(A_DATA,   32'h0001_116F, "sat_data");

        // Freeze blocks capture entirely
        wr(A_CTRL, 32'h0000_0001, "freeze_on_wr");
        check("freeze_on", {31'b0, ufreeze}, 32'h1);
        rd(A_CTRL, 32'h0000_0001, "freeze_ctrl");
        capture_seq(32'h1234_5678, 1);
        rd(A_STATUS, 32'h0000_0000, "frozen_status");
        rd(A_DATA,   32'h0001_116F, "frozen_data");
        wr(A_CTRL, 32'h0000_0000, "freeze_off_wr");
        check("freeze_off", {31'b0, ufreeze}, 32'h0);
        capture_seq(32'h1111_1111, 1);
        rd(A_STATUS, 32'h8000_0000, "resume_status");
        rd(A_DATA,   32'h1111_1111, "resume_data");

        // DATA read sampled at the same edge as a capture
        @(posedge clk);
        #1;
        abus   = A_DATA;
        rnw    = 1'b1;
        select = 1'b1;
        uvalid = 1'b1;
        udata  = 32'hA5A5_A5A5;
        exp_q.push_back('{data: 32'h1111_1111, cyc: cyc + 1, name: "same_cycle_read"});
        @(posedge clk);
        #1 uvalid = 1'b0;
        @(posedge clk);
        #1;
        select = 1'b0;
        rnw    = 1'b0;
        repeat (2) @(posedge clk);
        rd(A_STATUS, 32'h8000_0000, "same_cycle_status");
        rd(A_DATA,   32'hA5A5_A5A5, "same_cycle_data");

        // Long select: exactly one ack
        xfer(A_STATUS, 1'b1, 32'h0, 32'h0, 1'b1, "long_select", 5);

        // Just outside either end of the window
        xfer(BASE - 32'h4,  1'b1, 32'h0, 32'h0, 1'b0, "below_window", 2);
        xfer(BASE + 32'h10, 1'b1, 32'h0, 32'h0, 1'b0, "above_window", 2);

        // Reset in the cycle after a hit aborts the ack and clears state
        capture_seq(32'hBEEF_0001, 1);
        wr(A_CTRL, 32'h0000_0001, "pre_reset_freeze_wr");
        check("pre_reset_freeze", {31'b0, ufreeze}, 32'h1);
        @(posedge clk);
        #1;
        abus   = A_DATA;
        rnw    = 1'b1;
        select = 1'b1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        select = 1'b0;
        rnw    = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        rd(A_DATA,   32'h0, "post_reset_data");
        rd(A_STATUS, 32'h0, "post_reset_status");
        rd(A_CTRL,   32'h0, "post_reset_ctrl");

        repeat (4) @(posedge clk);
        check("pending_acks", exp_q.size(), 32'h0);
        check("unexpected_acks", unexpected, 32'h0);
        check("bus_violations", viol, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/opb_register_simulink2ppc_snap.md
# opb_register_simulink2ppc_snap

Read-side companion to the PPC-to-Simulink OPB register: captures a 32-bit word from user/DSP logic on a valid strobe and presents it to the PowerPC over the OPB slave interface. Adds a sticky fresh flag that clears on read, a saturating overrun counter and a freeze control, so software can poll firmware values coherently. Runs in the OPB clock domain only; user logic driving it must already be synchronous to OPB_Clk.

## Interface
- C_BASEADDR, 32'h00000000, first byte address of the 4-word window
- C_HIGHADDR, 32'h0000000F, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width
- C_FAMILY, "virtex6", target family string, unused in logic
- One clock; reset is asynchronous and active-high.
- OPB_Clk  in  1  sole clock
- OPB_Rst  in  1  asynchronous active-high reset
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables, ignored
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read, 0 = write
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  ignored
- Sl_DBus  out  [0:31]  read data, zero when not acknowledging
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_in  in  [31:0]  word to capture
- user_valid  in  1  capture strobe
- user_freeze  out  1  current freeze bit

## Operation
- Hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR. Word index is OPB_ABus[28:29].
- Map:
  - 0: DATA, R, captured word
  - 1: STATUS, R, bit31 = fresh, bits15:0 = overrun count, others 0; any write clears the overrun count
  - 2: CONTROL, R/W, bit0 = freeze (from OPB_DBus[31]), others read 0
  - 3: reads 0, writes ignored
- DATA writes are acknowledged and ignored.
- Bit order: Sl_DBus[0:31] = reg[31:0] by direct vector assignment, so Sl_DBus[31] = reg bit0. OPB_DBus uses the same mapping.
- Capture: user_valid=1 and freeze=0 loads data_reg <= user_data_in and sets fresh. If fresh was already 1, overrun increments, saturating at 16'hFFFF.
- With freeze=1, user_valid is ignored: no load and no count.
- A DATA read ack clears fresh.
- Same-cycle DATA read ack and capture: the read returns the old word; fresh stays 1; overrun does not increment from the read.
- Same-cycle STATUS write and overrunning capture: the clear wins, so count = 0.
- FSM:
  - IDLE -> ACK on a hit.
  - ACK: Sl_xferAck=1 for exactly one cycle; read data is driven; a write takes effect. Always -> HOLD.
  - HOLD: stays while OPB_select=1; -> IDLE when OPB_select=0.
  - No second ack until select has dropped.
- Reset values: all outputs 0; data_reg=0, fresh=0, overrun=0, freeze=0, FSM in IDLE.
- Reset asserted mid-transfer aborts with no ack.

## Timing
- Hit sampled at edge N; Sl_xferAck and Sl_DBus are registered and valid in cycle N+1 only. Sl_DBus=0 in every other cycle (bus is OR-combined).
- Read data is the register state at edge N, taken before any same-edge update.
- Capture latency: user_valid at edge N, then DATA and fresh show the new value to a hit sampled at edge N+1 or later.
- user_freeze reflects a CONTROL write from the edge ending the ACK cycle.
- Back-to-back captures are accepted every cycle.

## Structure
- Shared package holds:
  - word-index constants: IDX_DATA=0, IDX_STATUS=1, IDX_CONTROL=2
  - FSM state enum: IDLE, ACK, HOLD
  - STATUS bit positions
  - OVR_MAX=16'hFFFF
- One sub-module, opb_slave_ack_fsm: decodes the hit and generates the ack and the read/write strobes. It is reusable by other OPB registers.
- Capture, flag and counter logic live in the top level.

## Test plan
- Reset, then read all 4 words → 0, 0, 0, 0; each ack is exactly 1 cycle after select.
- One capture of 32'hDEADBEEF, then read STATUS → 32'h80000000; read DATA → Sl_DBus=32'hDEADBEEF; read STATUS again → 0.
- Three captures without a read → STATUS=32'h80000002. Write STATUS → 32'h80000000. Force 70000 overruns → count holds at 16'hFFFF.
- Write CONTROL=1 → user_freeze=1. A capture of 32'h12345678 is then ignored: DATA unchanged, fresh and count unchanged. Write CONTROL=0 → captures resume.
- DATA read ack in the same cycle as capturing 32'hA5A5A5A5 → read returns the prior word; the next STATUS read shows bit31=1.
- Select held for 5 cycles → one ack only. Out-of-window address → no ack, Sl_DBus=0. Reset in the cycle after a hit → no ack, all outputs 0.
